// File: rtl/synth_frame_sequencer_if.sv
// Host write port and shared parameter-RAM port of the synth frame sequencer.
// The sequencer takes the slave modport; the host/RAM side takes master.
interface synth_frame_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 16
) ();
    logic          host_req;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic          ram_wr;
    logic [DW-1:0] ram_wdata;

    modport slave (
        input  host_req, host_addr, host_wdata,
        output host_ack, ram_addr, ram_rd, ram_wr, ram_wdata
    );

    modport master (
        output host_req, host_addr, host_wdata,
        input  host_ack, ram_addr, ram_rd, ram_wr, ram_wdata
    );
endinterface

// File: rtl/synth_frame_sequencer.sv
// Per-sample slot sweep with engine-priority parameter RAM arbitration.
// Optional macro SYNTH_SEQ_OVERRUN_RESTART_EN: a trigger while busy restarts the frame.
module synth_frame_sequencer #(
    parameter int VOICES   = 32,
    parameter int V_ENVS   = 8,
    parameter int V_WIDTH  = 5,
    parameter int E_WIDTH  = 3,
    parameter int SLOT_DIV = 2,
    parameter int PARAM_DW = 16
) (
    input  logic                       AUDIO_CLK,
    input  logic                       reset_reg,
    input  logic                       trig,
    input  logic                       enable,
    output logic [V_WIDTH+E_WIDTH-1:0] slot_idx,
    output logic                       slot_valid,
    output logic                       frame_start,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       overrun,
    output logic [7:0]                 overrun_cnt,
    synth_frame_sequencer_if.slave     host_bus
);
    localparam int PH_W = $clog2(SLOT_DIV);
    localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(SLOT_DIV - 1);
    localparam logic [PH_W-1:0]    PH_ONE     = PH_W'(1);
    localparam logic [E_WIDTH-1:0] ENV_LAST   = E_WIDTH'(V_ENVS - 1);
    localparam logic [E_WIDTH-1:0] ENV_ONE    = E_WIDTH'(1);
    localparam logic [V_WIDTH-1:0] VOICE_LAST = V_WIDTH'(VOICES - 1);
    localparam logic [V_WIDTH-1:0] VOICE_ONE  = V_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [V_WIDTH-1:0]   voice_reg, voice_next;
    logic [E_WIDTH-1:0]   env_reg, env_next;
    logic [PH_W-1:0]      phase_reg, phase_next;
    logic                 trig_d_reg;
    logic                 overrun_reg, overrun_next;
    logic [7:0]           overrun_cnt_reg, overrun_cnt_next;

    logic                 trig_rise;
    logic                 start_req;
    logic                 busy_int;
    logic                 slot_valid_int;
    logic                 ram_wr_int;
    logic [PARAM_DW-1:0]  wdata_int;

    assign trig_rise = trig & ~trig_d_reg;
    assign start_req = trig_rise & enable;
    assign busy_int  = (state_reg != IDLE);

    always_ff @(posedge AUDIO_CLK) begin
        if (reset_reg) begin
            state_reg       <= IDLE;
            voice_reg       <= '0;
            env_reg         <= '0;
            phase_reg       <= '0;
            trig_d_reg      <= 1'b0;
            overrun_reg     <= 1'b0;
            overrun_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            voice_reg       <= voice_next;
            env_reg         <= env_next;
            phase_reg       <= phase_next;
            trig_d_reg      <= trig;
            overrun_reg     <= overrun_next;
            overrun_cnt_reg <= overrun_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        voice_next       = voice_reg;
        env_next         = env_reg;
        phase_next       = phase_reg;
        overrun_next     = overrun_reg;
        overrun_cnt_next = overrun_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start_req) begin
                    state_next = RUN;
                    voice_next = '0;
                    env_next   = '0;
                    phase_next = '0;
                end
            end
            RUN: begin
                if (phase_reg == PH_LAST) begin
                    phase_next = '0;
                    if (env_reg == ENV_LAST) begin
                        env_next = '0;
                        // Index parks at 0 once the last slot has been served
                        if (voice_reg == VOICE_LAST) begin
                            state_next = DONE;
                            voice_next = '0;
                        end else begin
                            voice_next = voice_reg + VOICE_ONE;
                        end
                    end else begin
                        env_next = env_reg + ENV_ONE;
                    end
                end else begin
                    phase_next = phase_reg + PH_ONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A disabled sequencer ignores triggers entirely, so they are not overruns
        if (busy_int && start_req) begin
            overrun_next = 1'b1;
            if (overrun_cnt_reg != 8'hFF) begin
                overrun_cnt_next = overrun_cnt_reg + 8'd1;
            end
`ifdef SYNTH_SEQ_OVERRUN_RESTART_EN
            state_next = RUN;
            voice_next = '0;
            env_next   = '0;
            phase_next = '0;
`endif
        end
    end

    assign slot_valid_int = (state_reg == RUN) && (phase_reg == '0);

    assign slot_idx    = {voice_reg, env_reg};
    assign slot_valid  = slot_valid_int;
    assign frame_start = slot_valid_int && (voice_reg == '0) && (env_reg == '0);
    assign frame_done  = (state_reg == DONE);
    assign busy        = busy_int;
    assign overrun     = overrun_reg;
    assign overrun_cnt = overrun_cnt_reg;

    // Engine owns phase 0 of every slot; the host gets every other cycle
    assign ram_wr_int = host_bus.host_req & ~slot_valid_int & ~reset_reg;
    assign wdata_int  = host_bus.host_wdata;

    assign host_bus.ram_rd    = slot_valid_int;
    assign host_bus.ram_wr    = ram_wr_int;
    assign host_bus.host_ack  = ram_wr_int;
    assign host_bus.ram_addr  = slot_valid_int ? slot_idx : host_bus.host_addr;
    assign host_bus.ram_wdata = wdata_int;
endmodule

// File: tb/tb_synth_frame_sequencer.sv
// Directed bench for synth_frame_sequencer at VOICES=2, V_ENVS=2, SLOT_DIV=2.
// Cycle k is counted from the trigger-edge cycle of each scenario (k=0).
module tb_synth_frame_sequencer;
    localparam int VOICES   = 2;
    localparam int V_ENVS   = 2;
    localparam int V_WIDTH  = 1;
    localparam int E_WIDTH  = 1;
    localparam int SLOT_DIV = 2;
    localparam int PARAM_DW = 16;
    localparam int AW       = V_WIDTH + E_WIDTH;

    logic           AUDIO_CLK = 1'b0;
    logic           reset_reg;
    logic           trig;
    logic           enable;
    logic [AW-1:0]  slot_idx;
    logic           slot_valid;
    logic           frame_start;
    logic           frame_done;
    logic           busy;
    logic           overrun;
    logic [7:0]     overrun_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 AUDIO_CLK = ~AUDIO_CLK;

    synth_frame_sequencer_if #(.AW(AW), .DW(PARAM_DW)) bus ();

    synth_frame_sequencer #(
        .VOICES(VOICES), .V_ENVS(V_ENVS), .V_WIDTH(V_WIDTH),
        .E_WIDTH(E_WIDTH), .SLOT_DIV(SLOT_DIV), .PARAM_DW(PARAM_DW)
    ) dut (
        .AUDIO_CLK  (AUDIO_CLK),
        .reset_reg  (reset_reg),
        .trig       (trig),
        .enable     (enable),
        .slot_idx   (slot_idx),
        .slot_valid (slot_valid),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun),
        .overrun_cnt(overrun_cnt),
        .host_bus   (bus.slave)
    );

    task automatic tick();
        @(posedge AUDIO_CLK);
        #1;
    endtask

    task automatic test_reset();
        reset_reg = 1'b1;
        trig = 1'b0;
        enable = 1'b0;
        bus.host_req = 1'b1;
        bus.host_addr = 2'd1;
        bus.host_wdata = 16'h1234;
        tick();
        tick();
        checks++;
        if (bus.ram_wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_host_block got=%b exp=0", bus.ram_wr);
        end
        checks++;
        if ({busy, slot_valid, frame_start, frame_done, overrun} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {busy, slot_valid, frame_start, frame_done, overrun});
        end
        checks++;
        if (overrun_cnt !== 8'd0 || slot_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_cnt_idx got=%h/%h exp=00/0", overrun_cnt, slot_idx);
        end
        reset_reg = 1'b0;
        bus.host_req = 1'b0;
        tick();
        bus.host_req = 1'b1;
        #1;
        checks++;
        if ({bus.ram_wr, bus.host_ack, bus.ram_addr, bus.ram_wdata} !== {1'b1, 1'b1, 2'd1, 16'h1234}) begin
            failures++;
            $display("FAIL idle_host_write got=%b%b/%h/%h exp=11/1/1234",
                     bus.ram_wr, bus.host_ack, bus.ram_addr, bus.ram_wdata);
        end
        $display("reset: idle host write addr=%h data=%h ack=%b", bus.ram_addr, bus.ram_wdata, bus.host_ack);
        bus.host_req = 1'b0;
        tick();
    endtask

    task automatic test_frame_timing();
        logic exp_sv, exp_fs, exp_fd, exp_busy;
        logic [AW-1:0] exp_idx;
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            trig = (k == 0);
            #1;
            exp_sv   = (k == 1) || (k == 3) || (k == 5) || (k == 7);
            exp_fs   = (k == 1);
            exp_fd   = (k == 9);
            exp_busy = (k >= 1) && (k <= 9);
            exp_idx  = AW'((k - 1) / 2);
            checks++;
            if ({slot_valid, frame_start, frame_done, busy, bus.ram_rd} !==
                {exp_sv, exp_fs, exp_fd, exp_busy, exp_sv}) begin
                failures++;
                $display("FAIL frame_flags k=%0d got=%b exp=%b", k,
                         {slot_valid, frame_start, frame_done, busy, bus.ram_rd},
                         {exp_sv, exp_fs, exp_fd, exp_busy, exp_sv});
            end
            if (exp_sv) begin
                checks++;
                if (slot_idx !== exp_idx || bus.ram_addr !== exp_idx) begin
                    failures++;
                    $display("FAIL frame_slot k=%0d got=%h/%h exp=%h", k, slot_idx, bus.ram_addr, exp_idx);
                end
                $display("frame: k=%0d slot=%h", k, slot_idx);
            end
            tick();
        end
        trig = 1'b0;
    endtask

    task automatic test_host_arb();
        logic exp_rd;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        bus.host_req = 1'b1;
        bus.host_addr = 2'd3;
        bus.host_wdata = 16'hA5A5;
        #1;
        for (int k = 1; k <= 10; k++) begin
            exp_rd = (k == 1) || (k == 3) || (k == 5) || (k == 7);
            checks++;
            if ({bus.ram_rd, bus.ram_wr, bus.host_ack} !== {exp_rd, ~exp_rd, ~exp_rd}) begin
                failures++;
                $display("FAIL arb_grant k=%0d got=%b exp=%b", k,
                         {bus.ram_rd, bus.ram_wr, bus.host_ack}, {exp_rd, ~exp_rd, ~exp_rd});
            end
            if (!exp_rd) begin
                checks++;
                if (bus.ram_addr !== 2'd3 || bus.ram_wdata !== 16'hA5A5) begin
                    failures++;
                    $display("FAIL arb_write k=%0d got=%h/%h exp=3/a5a5", k, bus.ram_addr, bus.ram_wdata);
                end
                $display("host: k=%0d ack addr=%h data=%h", k, bus.ram_addr, bus.ram_wdata);
            end
            tick();
        end
        bus.host_req = 1'b0;
        tick();
    endtask

    task automatic test_enable();
        logic exp_fs, exp_fd, exp_busy;
        enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            trig = (k == 0) || (k == 15);
            if (k == 3) enable = 1'b0;
            #1;
            exp_fs   = (k == 1);
            exp_fd   = (k == 9);
            exp_busy = (k >= 1) && (k <= 9);
            checks++;
            if ({frame_start, frame_done, busy} !== {exp_fs, exp_fd, exp_busy}) begin
                failures++;
                $display("FAIL enable_flags k=%0d got=%b exp=%b", k,
                         {frame_start, frame_done, busy}, {exp_fs, exp_fd, exp_busy});
            end
            tick();
        end
        trig = 1'b0;
        checks++;
        if (overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL enable_no_overrun got=%b/%0d exp=0/0", overrun, overrun_cnt);
        end
        $display("enable: disabled trigger ignored, overrun_cnt=%0d", overrun_cnt);
        enable = 1'b1;
        tick();
    endtask

    task automatic test_overrun();
        logic exp_fs, exp_fd, exp_busy;
        logic [AW-1:0] exp_idx5;
`ifdef SYNTH_SEQ_OVERRUN_RESTART_EN
        exp_idx5 = 2'd0;
`else
        exp_idx5 = 2'd2;
`endif
        for (int k = 0; k < 16; k++) begin
            trig = (k == 0) || (k == 4);
            #1;
`ifdef SYNTH_SEQ_OVERRUN_RESTART_EN
            exp_fs   = (k == 1) || (k == 5);
            exp_fd   = (k == 13);
            exp_busy = (k >= 1) && (k <= 13);
`else
            exp_fs   = (k == 1);
            exp_fd   = (k == 9);
            exp_busy = (k >= 1) && (k <= 9);
`endif
            checks++;
            if ({frame_start, frame_done, busy} !== {exp_fs, exp_fd, exp_busy}) begin
                failures++;
                $display("FAIL overrun_flags k=%0d got=%b exp=%b", k,
                         {frame_start, frame_done, busy}, {exp_fs, exp_fd, exp_busy});
            end
            if (k == 5) begin
                checks++;
                if (overrun !== 1'b1 || overrun_cnt !== 8'd1 || slot_idx !== exp_idx5) begin
                    failures++;
                    $display("FAIL overrun_first got=%b/%0d/%h exp=1/1/%h",
                             overrun, overrun_cnt, slot_idx, exp_idx5);
                end
                $display("overrun: k=5 cnt=%0d slot=%h", overrun_cnt, slot_idx);
            end
            tick();
        end
        for (int i = 0; i < 1000; i++) begin
            trig = (i % 2 == 1);
            tick();
        end
        trig = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (overrun_cnt !== 8'd255 || overrun !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL overrun_saturate got=%0d/%b/%b exp=255/1/0", overrun_cnt, overrun, busy);
        end
        $display("overrun: saturated cnt=%0d", overrun_cnt);
    endtask

    task automatic test_reset_midframe();
        logic exp_fs, exp_busy;
        for (int k = 0; k < 21; k++) begin
            trig = (k == 0) || (k == 10);
            reset_reg = (k == 6);
            bus.host_req = (k == 6);
            bus.host_addr = 2'd2;
            #1;
            if (k == 6) begin
                checks++;
                if (bus.ram_wr !== 1'b0) begin
                    failures++;
                    $display("FAIL midreset_host_block got=%b exp=0", bus.ram_wr);
                end
            end
            if (k == 7) begin
                checks++;
                if ({busy, slot_valid, frame_start, frame_done, overrun, overrun_cnt, slot_idx} !== 15'b0) begin
                    failures++;
                    $display("FAIL midreset_clear got=%b%b%b%b%b/%0d/%h exp=00000/0/0",
                             busy, slot_valid, frame_start, frame_done, overrun, overrun_cnt, slot_idx);
                end
            end
            if (k >= 7) begin
                exp_fs   = (k == 11);
                exp_busy = (k >= 11) && (k <= 19);
                checks++;
                if ({frame_start, frame_done, busy} !== {exp_fs, (k == 19), exp_busy}) begin
                    failures++;
                    $display("FAIL midreset_flags k=%0d got=%b exp=%b", k,
                             {frame_start, frame_done, busy}, {exp_fs, (k == 19), exp_busy});
                end
                if (k == 11) begin
                    checks++;
                    if (slot_idx !== 2'd0 || slot_valid !== 1'b1) begin
                        failures++;
                        $display("FAIL midreset_restart got=%h/%b exp=0/1", slot_idx, slot_valid);
                    end
                end
            end
            tick();
        end
        trig = 1'b0;
        bus.host_req = 1'b0;
        $display("reset_midframe: clean frame after abort");
    endtask

    initial begin
        reset_reg = 1'b1;
        trig = 1'b0;
        enable = 1'b0;
        bus.host_req = 1'b0;
        bus.host_addr = '0;
        bus.host_wdata = '0;
        test_reset();
        test_frame_timing();
        test_host_arb();
        test_enable();
        test_overrun();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/synth_frame_sequencer.md
Name: synth_frame_sequencer

Overview:
Per-sample frame sequencer for the synth engine. On each sample-rate trigger it sweeps the voice/envelope slot index across all VOICES*V_ENVS slots at a fixed clocks-per-slot rate, issuing one engine read strobe per slot. It also arbitrates the shared per-slot parameter RAM between the engine sweep, which has fixed priority, and a host (MIDI/CPU) write port. It sits between the sample-rate trigger source and the oscillator/envelope datapath, replacing the free-running divider and index counter.

Parameters:
VOICES, 32, number of voices
V_ENVS, 8, envelope/osc slots per voice
V_WIDTH, 5, voice index width (2**V_WIDTH >= VOICES)
E_WIDTH, 3, slot-within-voice width (2**E_WIDTH >= V_ENVS)
SLOT_DIV, 2, AUDIO_CLK cycles per slot; legal range 2..16
PARAM_DW, 16, parameter RAM data width

Ports:
AUDIO_CLK  in  1  sole clock
reset_reg  in  1  synchronous, active-high reset
trig  in  1  sample-rate trigger, already synchronous to AUDIO_CLK; rising edge starts a frame
enable  in  1  level; gates frame starts only
slot_idx  out  V_WIDTH+E_WIDTH  current slot, {voice, env}; valid while busy
slot_valid  out  1  1-cycle strobe on phase 0 of each slot
frame_start  out  1  1-cycle pulse with slot 0 strobe
frame_done  out  1  1-cycle pulse after last slot
busy  out  1  high in RUN and DONE
overrun  out  1  sticky; trig edge seen while busy
overrun_cnt  out  8  saturating count of overruns
ram_addr  out  V_WIDTH+E_WIDTH  parameter RAM address
ram_rd  out  1  engine read enable (= slot_valid)
ram_wr  out  1  host write enable
ram_wdata  out  PARAM_DW  = host_wdata
host_req  in  1  write request; hold with addr/data until ack
host_addr  in  V_WIDTH+E_WIDTH  write address
host_wdata  in  PARAM_DW  write data
host_ack  out  1  = ram_wr; write committed this cycle

Behaviour:
- Reset (sync, active-high): state IDLE; slot_idx=0, phase=0, trig_d=0. All outputs 0, including overrun and overrun_cnt. Host writes blocked during the reset cycle. Reset mid-frame aborts the frame with no frame_done.
- Edge detect: trig_rise = trig & ~trig_d, with trig_d registered.
- States: IDLE, RUN, DONE. Slot index count: N = VOICES*V_ENVS. slot_idx = {voice[V_WIDTH-1:0], env[E_WIDTH-1:0]}. env wraps at V_ENVS-1, then voice increments. Unused codes are never issued.
- IDLE -> RUN when trig_rise & enable in cycle T. At T+1: slot_idx=0, phase=0, slot_valid=1, frame_start=1.
- RUN: phase counts 0..SLOT_DIV-1. slot_valid and ram_rd are high only at phase 0. slot_idx advances when phase wraps.
- RUN -> DONE after phase SLOT_DIV-1 of slot N-1. frame_done=1 for the single DONE cycle, at T+1+N*SLOT_DIV. DONE -> IDLE next cycle.
- A frame takes exactly N*SLOT_DIV RUN cycles plus 1 DONE cycle.
- enable low mid-frame: the current frame completes normally; new triggers are ignored without counting as overrun.
- trig_rise while busy: overrun<=1; overrun_cnt increments and saturates at 255. The trigger is dropped (see optional feature).
- RAM mux (combinational): ram_wr = host_req & ~ram_rd. ram_addr = ram_rd ? slot_idx : host_addr.
- Host writes are granted in any non-phase-0 cycle, including all of IDLE and DONE. Back-to-back acks are allowed. Max host wait is 1 cycle since SLOT_DIV >= 2.
- Host write and engine read are never simultaneous. The engine is never stalled.
- Host-side requirement: after ack, present the next request or drop req in the following cycle.

Optional Feature:
SYNTH_SEQ_OVERRUN_RESTART_EN
- Undefined: trig_rise while busy is counted and dropped; the current frame runs to completion.
- Defined: trig_rise while busy is counted and aborts the frame. The next cycle is slot_idx=0, phase=0, slot_valid=1, frame_start=1 in RUN. No frame_done is issued for the aborted frame.

Test Plan:
1. Frame timing (VOICES=2, V_ENVS=2, SLOT_DIV=2): trig edge at cycle 10 -> frame_start and slot_valid at 11. slot_valid at 11/13/15/17 with slot_idx 0,1,2,3 ({v,e} = 00,01,10,11 at E_WIDTH=1). frame_done at 19; busy low at 20.
2. Host arbitration: host_req held high throughout a frame with addr=3, data=0xA5A5 -> ram_wr never coincides with ram_rd. The first ack lands on the first non-phase-0 cycle; ram_addr=3 and ram_wdata=0xA5A5 on that cycle.
3. Overrun, default build: second trig edge at cycle 14 -> overrun=1 and overrun_cnt=1. Frame still ends with frame_done at 19; no new frame_start. 300 overruns -> overrun_cnt=255.
4. Overrun, SYNTH_SEQ_OVERRUN_RESTART_EN build: trig edge at 14 -> frame_start and slot_idx=0 at 15. frame_done at 23 only.
5. enable=0 at cycle 13 -> frame finishes (frame_done at 19). A trig at 25 -> no frame and overrun_cnt unchanged.
6. reset_reg=1 at cycle 15 mid-frame -> at 16 all outputs 0 and state IDLE, no frame_done. A trig at 20 starts a clean frame at 21.
